// File: rtl/fire_target_scheduler.sv
// Fire-point target scheduler: two oldest-first class queues (priority window / normal) feeding
// a nozzle aimer one target at a time through an issue handshake and a done-or-timeout wait.
module fire_target_scheduler #(
  parameter int unsigned COORD_W = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COORD_W-1:0]     prio_start_x,
  input  logic [COORD_W-1:0]     prio_start_y,
  input  logic [COORD_W-1:0]     prio_end_x,
  input  logic [COORD_W-1:0]     prio_end_y,
  input  logic                   det_valid,
  output logic                   det_ready,
  input  logic [COORD_W-1:0]     det_x,
  input  logic [COORD_W-1:0]     det_y,
  output logic                   tgt_valid,
  input  logic                   tgt_ready,
  output logic [COORD_W-1:0]     tgt_x,
  output logic [COORD_W-1:0]     tgt_y,
  output logic                   tgt_prio,
  input  logic                   svc_done,
  output logic                   svc_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] hi_count,
  output logic [$clog2(DEPTH):0] lo_count
);

  localparam int unsigned PW = 2 * COORD_W;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [PW-1:0]      hi_q [DEPTH];
  logic [PW-1:0]      hi_d [DEPTH];
  logic [PW-1:0]      lo_q [DEPTH];
  logic [PW-1:0]      lo_d [DEPTH];
  logic [CW-1:0]      hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic [1:0]         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [COORD_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic               tgt_prio_q, tgt_prio_d;
  logic               timeout_q, timeout_d;

  logic [PW-1:0] det_pt;
  logic          in_win, dup, accept;
  logic          push_hi, push_lo, pop_hi, pop_lo;
  logic [AW-1:0] hi_widx, lo_widx;

  assign det_ready = !reset && (hi_cnt_q != CW'(DEPTH)) && (lo_cnt_q != CW'(DEPTH));

  // Duplicate check sees queue contents before any same-cycle pop.
  always_comb begin
    det_pt = {det_x, det_y};
    in_win = (det_x >= prio_start_x) && (det_x <= prio_end_x) &&
             (det_y >= prio_start_y) && (det_y <= prio_end_y);
    dup    = (state_q != StIdle) && ({tgt_x_q, tgt_y_q} == det_pt);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < hi_cnt_q) && (hi_q[AW'(i)] == det_pt)) dup = 1'b1;
      if ((CW'(i) < lo_cnt_q) && (lo_q[AW'(i)] == det_pt)) dup = 1'b1;
    end
    accept  = det_valid && det_ready;
    push_hi = accept && !dup && in_win;
    push_lo = accept && !dup && !in_win;
    pop_hi  = (state_q == StIdle) && (hi_cnt_q != '0);
    pop_lo  = (state_q == StIdle) && (hi_cnt_q == '0) && (lo_cnt_q != '0);
    hi_widx = AW'(pop_hi ? hi_cnt_q - CW'(1) : hi_cnt_q);
    lo_widx = AW'(pop_lo ? lo_cnt_q - CW'(1) : lo_cnt_q);
  end

  // Entry 0 is always the oldest; a pop shifts, a push lands just past the survivors.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (pop_hi) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) hi_d[AW'(i)] = hi_q[AW'(i + 1)];
      hi_cnt_d = hi_cnt_d - CW'(1);
    end
    if (pop_lo) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) lo_d[AW'(i)] = lo_q[AW'(i + 1)];
      lo_cnt_d = lo_cnt_d - CW'(1);
    end
    if (push_hi) begin
      hi_d[hi_widx] = det_pt;
      hi_cnt_d      = hi_cnt_d + CW'(1);
    end
    if (push_lo) begin
      lo_d[lo_widx] = det_pt;
      lo_cnt_d      = lo_cnt_d + CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    tgt_prio_d = tgt_prio_q;
    timeout_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pop_hi) begin
          {tgt_x_d, tgt_y_d} = hi_q[0];
          tgt_prio_d         = 1'b1;
          state_d            = StIssue;
        end else if (pop_lo) begin
          {tgt_x_d, tgt_y_d} = lo_q[0];
          tgt_prio_d         = 1'b0;
          state_d            = StIssue;
        end
      end
      StIssue: begin
        if (tgt_ready) begin
          state_d = StWait;
          timer_d = '0;
        end
      end
      StWait: begin
        timer_d = timer_q + TW'(1);
        if (svc_done) begin
          state_d = StIdle;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      state_q    <= StIdle;
      timer_q    <= '0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      tgt_prio_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      tgt_prio_q <= tgt_prio_d;
      timeout_q  <= timeout_d;
    end
  end

  // Entry storage needs no reset: only slots below the count are ever observed.
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  assign tgt_valid   = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign tgt_x       = tgt_x_q;
  assign tgt_y       = tgt_y_q;
  assign tgt_prio    = tgt_prio_q;
  assign svc_timeout = timeout_q;
  assign hi_count    = hi_cnt_q;
  assign lo_count    = lo_cnt_q;

endmodule

// File: tb/tb_fire_target_scheduler.sv
// Bench for fire_target_scheduler: directed scenarios plus random traffic, all checked each
// cycle against a queue-based reference model of the scheduling rules.
module tb_fire_target_scheduler;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] prio_start_x = 2'd1, prio_start_y = 2'd1, prio_end_x = 2'd2, prio_end_y = 2'd2;
  logic       det_valid = 1'b0, det_ready;
  logic [1:0] det_x = '0, det_y = '0;
  logic       tgt_valid, tgt_ready = 1'b0;
  logic [1:0] tgt_x, tgt_y;
  logic       tgt_prio, svc_done = 1'b0, svc_timeout, busy;
  logic [2:0] hi_count, lo_count;

  always #5 clk = ~clk;

  fire_target_scheduler #(.COORD_W(2), .DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .prio_start_x(prio_start_x), .prio_start_y(prio_start_y),
    .prio_end_x(prio_end_x), .prio_end_y(prio_end_y),
    .det_valid(det_valid), .det_ready(det_ready), .det_x(det_x), .det_y(det_y),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_x(tgt_x), .tgt_y(tgt_y),
    .tgt_prio(tgt_prio), .svc_done(svc_done), .svc_timeout(svc_timeout), .busy(busy),
    .hi_count(hi_count), .lo_count(lo_count)
  );

  int checks = 0;
  int errors = 0;
  bit acc;
  logic [4:0] issued[$];

  // Reference model: phase 0 idle, 1 offering, 2 servicing.
  logic [3:0] m_hq[$];
  logic [3:0] m_lq[$];
  int         m_phase = 0;
  int         m_timer = 0;
  logic [1:0] m_cx = '0, m_cy = '0;
  logic       m_cp = 1'b0, m_to = 1'b0;

  function automatic logic m_ready();
    return !reset && (m_hq.size() < 4) && (m_lq.size() < 4);
  endfunction

  function automatic logic [14:0] m_outputs();
    return {m_ready(), m_phase == 1, m_cx, m_cy, m_cp, m_to, m_phase != 0,
            3'(m_hq.size()), 3'(m_lq.size())};
  endfunction

  task automatic model_update();
    logic [3:0] pt, head;
    logic       is_dup, is_hi, take;
    if (reset) begin
      m_hq.delete(); m_lq.delete();
      m_phase = 0; m_timer = 0; m_cx = '0; m_cy = '0; m_cp = 1'b0; m_to = 1'b0;
      return;
    end
    pt     = {det_x, det_y};
    take   = det_valid && m_ready();
    is_dup = (m_phase != 0) && (pt == {m_cx, m_cy});
    foreach (m_hq[i]) if (m_hq[i] == pt) is_dup = 1'b1;
    foreach (m_lq[i]) if (m_lq[i] == pt) is_dup = 1'b1;
    is_hi  = (det_x >= prio_start_x) && (det_x <= prio_end_x) &&
             (det_y >= prio_start_y) && (det_y <= prio_end_y);
    m_to = 1'b0;
    if (m_phase == 0) begin
      if (m_hq.size() > 0) begin
        head = m_hq.pop_front(); {m_cx, m_cy} = head; m_cp = 1'b1; m_phase = 1;
      end else if (m_lq.size() > 0) begin
        head = m_lq.pop_front(); {m_cx, m_cy} = head; m_cp = 1'b0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (tgt_ready) begin m_phase = 2; m_timer = 0; end
    end else begin
      if (svc_done) m_phase = 0;
      else if (m_timer == int'(TO) - 1) begin m_to = 1'b1; m_phase = 0; end
      else m_timer++;
    end
    if (take && !is_dup) begin
      if (is_hi) m_hq.push_back(pt);
      else m_lq.push_back(pt);
    end
  endtask

  // Called with inputs applied just after a falling edge; returns at the next falling edge.
  task automatic tick();
    logic [14:0] obs, exp;
    #1;
    exp = m_outputs();
    obs = {det_ready, tgt_valid, tgt_x, tgt_y, tgt_prio, svc_timeout, busy, hi_count, lo_count};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL model t=%0t: observed %b expected %b", $time, obs, exp);
    end
    acc = det_valid && det_ready;
    if (tgt_valid && tgt_ready) issued.push_back({tgt_prio, tgt_x, tgt_y});
    model_update();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y);
    det_x = 2'(x); det_y = 2'(y); det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
  endtask

  initial begin
    int ws, pa, np;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Priority window beats age; lo targets stay oldest first.
    issued.delete();
    push(3, 0); push(0, 0); push(3, 3); push(1, 2);
    tgt_ready = 1'b1; svc_done = 1'b1;
    repeat (15) tick();
    tgt_ready = 1'b0; svc_done = 1'b0;
    chk("order_n", issued.size(), 4);
    if (issued.size() == 4) begin
      chk("order_0", int'(issued[0]), 12);
      chk("order_1", int'(issued[1]), 22);
      chk("order_2", int'(issued[2]), 0);
      chk("order_3", int'(issued[3]), 15);
    end

    // Latency and issue hold.
    push(2, 1);
    chk("lat_n1_valid", int'(tgt_valid), 0);
    tick();
    chk("lat_n2_valid", int'(tgt_valid), 1);
    repeat (5) tick();
    chk("hold_valid", int'(tgt_valid), 1);
    chk("hold_x", int'(tgt_x), 2);
    chk("hold_y", int'(tgt_y), 1);
    chk("hold_prio", int'(tgt_prio), 1);
    tgt_ready = 1'b1; tick(); tgt_ready = 1'b0;
    chk("wait_valid", int'(tgt_valid), 0);
    chk("wait_busy", int'(busy), 1);
    svc_done = 1'b1; tick(); svc_done = 1'b0;
    chk("done_busy", int'(busy), 0);

    // Duplicates against queue and in-service target.
    issued.delete();
    push(1, 1);
    chk("dup_hi1", int'(hi_count), 1);
    push(1, 1);
    chk("dup_hi2", int'(hi_count), 0);
    push(1, 1);
    chk("dup_hi3", int'(hi_count), 0);
    tgt_ready = 1'b1; svc_done = 1'b1;
    repeat (6) tick();
    tgt_ready = 1'b0; svc_done = 1'b0;
    chk("dup_issued_n", issued.size(), 1);
    if (issued.size() == 1) chk("dup_issued_pt", int'(issued[0]), 21);

    // Full normal queue back-pressures the sensor.
    push(0, 0); push(0, 1); push(0, 2); push(0, 3); push(3, 0);
    chk("full_lo", int'(lo_count), 4);
    chk("full_ready", int'(det_ready), 0);
    chk("full_tx", int'({tgt_x, tgt_y}), 0);
    det_x = 2'd3; det_y = 2'd1; det_valid = 1'b1;
    repeat (3) tick();
    chk("full_blocked", int'(acc), 0);
    chk("full_lo_held", int'(lo_count), 4);
    tgt_ready = 1'b1; tick(); tgt_ready = 1'b0;
    svc_done = 1'b1; tick(); svc_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc) break;
    end
    det_valid = 1'b0;
    chk("full_accept_after_pop", int'(acc), 1);
    chk("full_lo_after", int'(lo_count), 4);
    tgt_ready = 1'b1; svc_done = 1'b1;
    repeat (20) tick();
    tgt_ready = 1'b0; svc_done = 1'b0;
    chk("drain_lo", int'(lo_count), 0);
    chk("drain_busy", int'(busy), 0);

    // Timeout pulse, then done coincident with the last wait cycle.
    tgt_ready = 1'b1;
    push(3, 3);
    ws = -1; pa = -1; np = 0;
    for (int k = 0; k < 30; k++) begin
      if (ws < 0 && busy && !tgt_valid) ws = k;
      if (svc_timeout) begin np++; pa = k; end
      tick();
    end
    chk("to_pulses", np, 1);
    chk("to_delay", pa - ws, 8);
    push(3, 2);
    ws = -1; np = 0;
    for (int k = 0; k < 30; k++) begin
      if (ws < 0 && busy && !tgt_valid) ws = k;
      if (svc_timeout) np++;
      svc_done = (ws >= 0) && (k == ws + 7);
      tick();
    end
    svc_done = 1'b0;
    chk("done_wins_pulses", np, 0);
    chk("done_wins_busy", int'(busy), 0);

    // Reset in the middle of service with entries queued.
    push(2, 2); push(1, 1); push(3, 3); push(1, 2);
    chk("pre_rst_hi", int'(hi_count), 2);
    chk("pre_rst_lo", int'(lo_count), 1);
    reset = 1'b1;
    tick();
    chk("rst_outputs", int'({det_ready, tgt_valid, tgt_x, tgt_y, tgt_prio, svc_timeout, busy,
                             hi_count, lo_count}), 0);
    tick();
    reset = 1'b0;
    tgt_ready = 1'b0;
    tick();
    chk("post_rst_ready", int'(det_ready), 1);
    chk("post_rst_counts", int'({hi_count, lo_count}), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if (c % 60 == 0) begin
        prio_start_x = 2'($urandom); prio_start_y = 2'($urandom);
        prio_end_x   = 2'($urandom); prio_end_y   = 2'($urandom);
      end
      det_valid = 1'($urandom);
      det_x     = 2'($urandom);
      det_y     = 2'($urandom);
      tgt_ready = ($urandom_range(0, 3) != 0);
      svc_done  = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; det_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
